// File: rtl/sdm_sample_sequencer_if.sv
// Host-side sample stream for sdm_sample_sequencer: a valid/ready push of one 16-bit word.
// The host drives the master modport; the sequencer takes the slave modport.
interface sdm_sample_sequencer_if;
    logic        S_VALID;
    logic [15:0] S_DATA;
    logic        S_READY;

    modport master (
        output S_VALID,
        output S_DATA,
        input  S_READY
    );

    modport slave (
        input  S_VALID,
        input  S_DATA,
        output S_READY
    );
endinterface

// File: rtl/sdm_sample_sequencer.sv
// Feeds host samples to a sigma-delta modulator, holding each word for 2^OSR_LOG2 clocks.
// Optional build macro SDM_SEQ_UNDERRUN_CNT_EN adds a saturating UNDERRUN_COUNT output.
module sdm_sample_sequencer #(
    parameter int OSR_LOG2     = 6,
    parameter int FIFO_DEPTH   = 4,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    sdm_sample_sequencer_if.slave s_if,
    output logic [15:0]           DATAWORD_OUT,
    output logic                  MOD_RESET_N,
    output logic                  SAMPLE_STROBE,
    output logic                  UNDERRUN,
    output logic                  BUSY
`ifdef SDM_SEQ_UNDERRUN_CNT_EN
    ,
    output logic [15:0]           UNDERRUN_COUNT
`endif
);

    localparam int DATA_W = 16;
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [7:0]          FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
    localparam logic [7:0]          FLUSH_ONE  = 8'd1;
    localparam logic [OSR_LOG2-1:0] OSR_ONE    = OSR_LOG2'(1);
    localparam logic [AW:0]         PTR_ONE    = (AW + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_RUN      = 2'd2,
        ST_UNDERRUN = 2'd3
    } state_t;

    // Sample FIFO: pointers carry one extra wrap bit so full and empty differ.
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_flush_cnt;
    logic [OSR_LOG2-1:0]   r_osr_cnt;
    logic                  w_osr_tc;
    logic                  w_flush_done;

    logic [DATA_W-1:0]     r_dataword;
    logic                  r_mod_reset_n;
    logic                  r_strobe;
    logic                  r_underrun;
    logic                  r_busy;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign s_if.S_READY = !w_full;
    assign w_push       = s_if.S_VALID && !w_full;

    assign w_osr_tc     = &r_osr_cnt;
    assign w_flush_done = (r_flush_cnt == FLUSH_LAST);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage is pure data; validity is tracked entirely by the pointers.
    always_ff @(posedge CLOCK) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= s_if.S_DATA;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Pops are decided from registered FIFO state only, so a same-cycle push never feeds them.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ENABLE && !w_empty) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!ENABLE) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_flush_done) begin
                    w_state_nxt = ST_RUN;
                    w_pop       = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_osr_tc) begin
                    if (!ENABLE)      w_state_nxt = ST_IDLE;
                    else if (w_empty) w_state_nxt = ST_UNDERRUN;
                    else              w_pop       = 1'b1;
                end
            end
            ST_UNDERRUN: begin
                if (!ENABLE) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_empty) begin
                    w_state_nxt = ST_RUN;
                    w_pop       = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_flush_cnt <= '0;
            r_osr_cnt   <= '0;
        end else begin
            if (r_state == ST_FLUSH && w_state_nxt == ST_FLUSH) r_flush_cnt <= r_flush_cnt + FLUSH_ONE;
            else                                                r_flush_cnt <= '0;

            // Each loaded sample restarts the period; the counter wraps naturally at terminal count.
            if (w_pop || w_state_nxt != ST_RUN) r_osr_cnt <= '0;
            else                                r_osr_cnt <= r_osr_cnt + OSR_ONE;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_dataword    <= '0;
            r_mod_reset_n <= 1'b0;
            r_strobe      <= 1'b0;
            r_underrun    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            if (w_pop)                         r_dataword <= r_mem[r_rd_ptr[AW-1:0]];
            else if (w_state_nxt == ST_IDLE)   r_dataword <= '0;
            r_mod_reset_n <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_UNDERRUN);
            r_strobe      <= w_pop;
            r_underrun    <= (w_state_nxt == ST_UNDERRUN);
            r_busy        <= (w_state_nxt != ST_IDLE);
        end
    end

    assign DATAWORD_OUT  = r_dataword;
    assign MOD_RESET_N   = r_mod_reset_n;
    assign SAMPLE_STROBE = r_strobe;
    assign UNDERRUN      = r_underrun;
    assign BUSY          = r_busy;

`ifdef SDM_SEQ_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_underrun_cnt <= '0;
        end else if (r_state == ST_RUN && w_state_nxt == ST_UNDERRUN &&
                     r_underrun_cnt != 16'hFFFF) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign UNDERRUN_COUNT = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_sdm_sample_sequencer.sv
// Bench for sdm_sample_sequencer (OSR_LOG2=2, FIFO_DEPTH=4, FLUSH_CYCLES=4): directed stimulus,
// with a strobe-driven scoreboard checking word order and 4-clock sample spacing.
module tb_sdm_sample_sequencer;

    localparam int OSR_LOG2     = 2;
    localparam int FIFO_DEPTH   = 4;
    localparam int FLUSH_CYCLES = 4;

    logic        CLOCK  = 1'b0;
    logic        RESET  = 1'b0;
    logic        ENABLE = 1'b0;
    logic [15:0] DATAWORD_OUT;
    logic        MOD_RESET_N;
    logic        SAMPLE_STROBE;
    logic        UNDERRUN;
    logic        BUSY;
`ifdef SDM_SEQ_UNDERRUN_CNT_EN
    logic [15:0] UNDERRUN_COUNT;
`endif

    sdm_sample_sequencer_if s_if ();

    sdm_sample_sequencer #(
        .OSR_LOG2     (OSR_LOG2),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .ENABLE        (ENABLE),
        .s_if          (s_if),
        .DATAWORD_OUT  (DATAWORD_OUT),
        .MOD_RESET_N   (MOD_RESET_N),
        .SAMPLE_STROBE (SAMPLE_STROBE),
        .UNDERRUN      (UNDERRUN),
        .BUSY          (BUSY)
`ifdef SDM_SEQ_UNDERRUN_CNT_EN
        ,
        .UNDERRUN_COUNT(UNDERRUN_COUNT)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    int          n_checks    = 0;
    int          n_fail      = 0;
    int          cyc         = 0;
    int          last_strobe = -1;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    function automatic bit probe(input int sel);
        case (sel)
            0:       return !BUSY;
            1:       return UNDERRUN;
            2:       return MOD_RESET_N;
            default: return s_if.S_READY;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int limit, input string name, output int n);
        n = 0;
        while (!probe(sel) && n < limit) begin
            tick();
            n++;
        end
        check(name, {31'd0, probe(sel)}, 32'd1);
    endtask

    task automatic wait_dw(input logic [15:0] d, input string name);
        int n = 0;
        while (DATAWORD_OUT !== d && n < 40) begin
            tick();
            n++;
        end
        check(name, {16'd0, DATAWORD_OUT}, {16'd0, d});
    endtask

    task automatic push(input logic [15:0] d);
        int n = 0;
        s_if.S_VALID = 1'b1;
        s_if.S_DATA  = d;
        while (!s_if.S_READY && n < 40) begin
            tick();
            n++;
        end
        check("push_ready", {31'd0, s_if.S_READY}, 32'd1);
        exp_q.push_back(d);
        tick();
        s_if.S_VALID = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge CLOCK);
            cyc <= cyc + 1;
        end
    end

    // Monitor: every strobe must present the next queued word, 4 clocks after the previous one.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge CLOCK);
            if (SAMPLE_STROBE === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("strobe_unexpected", {16'd0, DATAWORD_OUT}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_data", {16'd0, DATAWORD_OUT}, {16'd0, e});
                    check("strobe_mod_reset_n", {31'd0, MOD_RESET_N}, 32'd1);
                    if (last_strobe >= 0) check("strobe_gap", cyc - last_strobe, 32'd4);
                end
                last_strobe = cyc;
            end else if (BUSY !== 1'b1 || UNDERRUN === 1'b1) begin
                last_strobe = -1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d, expected test end", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        s_if.S_VALID = 1'b0;
        s_if.S_DATA  = '0;

        repeat (3) tick();
        check("rst_dataword", {16'd0, DATAWORD_OUT}, 32'd0);
        check("rst_mod_reset_n", {31'd0, MOD_RESET_N}, 32'd0);
        check("rst_strobe", {31'd0, SAMPLE_STROBE}, 32'd0);
        check("rst_underrun", {31'd0, UNDERRUN}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        RESET = 1'b1;
        check("rst_s_ready", {31'd0, s_if.S_READY}, 32'd1);
        tick();

        // Single sample: flush, run, underrun, recovery, then stop.
        ENABLE = 1'b1;
        push(16'h1000);
        tick();
        check("flush_busy", {31'd0, BUSY}, 32'd1);
        check("flush_mod_reset_n", {31'd0, MOD_RESET_N}, 32'd0);
        wait_for(2, 20, "flush_end", n);
        check("flush_len", n, 32'd4);
        check("first_dataword", {16'd0, DATAWORD_OUT}, 32'h1000);
        check("first_strobe", {31'd0, SAMPLE_STROBE}, 32'd1);
        check("first_busy", {31'd0, BUSY}, 32'd1);
        wait_for(1, 20, "underrun_entry", n);
        check("underrun_delay", n, 32'd4);
        check("underrun_hold", {16'd0, DATAWORD_OUT}, 32'h1000);
        check("underrun_mod_reset_n", {31'd0, MOD_RESET_N}, 32'd1);
        push(16'h0ABC);
        tick();
        check("recover_dataword", {16'd0, DATAWORD_OUT}, 32'h0ABC);
        check("recover_underrun", {31'd0, UNDERRUN}, 32'd0);
        check("recover_strobe", {31'd0, SAMPLE_STROBE}, 32'd1);
`ifdef SDM_SEQ_UNDERRUN_CNT_EN
        check("underrun_count", {16'd0, UNDERRUN_COUNT}, 32'd1);
`endif
        ENABLE = 1'b0;
        wait_for(0, 20, "idle_after_run", n);
        check("idle_dataword", {16'd0, DATAWORD_OUT}, 32'd0);
        check("idle_mod_reset_n", {31'd0, MOD_RESET_N}, 32'd0);

        // Prefill three words, then run them back to back.
        push(16'h0100);
        push(16'h0200);
        push(16'h0300);
        ENABLE = 1'b1;
        wait_dw(16'h0300, "seq_last_word");
        wait_for(1, 20, "seq_underrun", n);
        ENABLE = 1'b0;
        wait_for(0, 20, "seq_idle", n);

        // Fill the FIFO; the fifth word waits for the first pop.
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        push(16'h4444);
        check("full_s_ready", {31'd0, s_if.S_READY}, 32'd0);
        s_if.S_VALID = 1'b1;
        s_if.S_DATA  = 16'h5555;
        repeat (3) tick();
        check("held_off_s_ready", {31'd0, s_if.S_READY}, 32'd0);
        ENABLE = 1'b1;
        push(16'h5555);

        // Drop ENABLE with the OSR counter at 1: the period still completes.
        wait_dw(16'h2222, "drop_word");
        tick();
        ENABLE = 1'b0;
        tick();
        check("drop_busy_2", {31'd0, BUSY}, 32'd1);
        check("drop_hold_2", {16'd0, DATAWORD_OUT}, 32'h2222);
        tick();
        check("drop_busy_3", {31'd0, BUSY}, 32'd1);
        check("drop_hold_3", {16'd0, DATAWORD_OUT}, 32'h2222);
        tick();
        check("drop_idle_busy", {31'd0, BUSY}, 32'd0);
        check("drop_idle_mod_reset_n", {31'd0, MOD_RESET_N}, 32'd0);
        check("drop_idle_dataword", {16'd0, DATAWORD_OUT}, 32'd0);
        check("drop_fifo_ready", {31'd0, s_if.S_READY}, 32'd1);
        check("drop_fifo_pending", exp_q.size(), 32'd3);

        // Resume, then reset asynchronously in the middle of a sample period.
        ENABLE = 1'b1;
        wait_dw(16'h4444, "resume_word");
        tick();
        #2;
        RESET = 1'b0;
        #1;
        check("async_dataword", {16'd0, DATAWORD_OUT}, 32'd0);
        check("async_mod_reset_n", {31'd0, MOD_RESET_N}, 32'd0);
        check("async_strobe", {31'd0, SAMPLE_STROBE}, 32'd0);
        check("async_underrun", {31'd0, UNDERRUN}, 32'd0);
        check("async_busy", {31'd0, BUSY}, 32'd0);
        check("async_s_ready", {31'd0, s_if.S_READY}, 32'd1);
`ifdef SDM_SEQ_UNDERRUN_CNT_EN
        check("async_underrun_count", {16'd0, UNDERRUN_COUNT}, 32'd0);
`endif
        exp_q.delete();
        tick();
        RESET = 1'b1;
        check("post_rst_s_ready", {31'd0, s_if.S_READY}, 32'd1);

        // After reset the sequencer starts cleanly from an empty FIFO.
        push(16'h7777);
        wait_for(2, 20, "post_rst_run", n);
        check("post_rst_dataword", {16'd0, DATAWORD_OUT}, 32'h7777);
        ENABLE = 1'b0;
        wait_for(0, 20, "post_rst_idle", n);
        repeat (2) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdm_sample_sequencer.md
SDM_SAMPLE_SEQUENCER -- requirements
Module: sdm_sample_sequencer

Interface
REQ-001 Parameter OSR_LOG2, default 6: log2 of modulator clocks per input sample; legal range 1..10.
REQ-002 Parameter FIFO_DEPTH, default 4: sample FIFO entries; power of two, 2..16.
REQ-003 Parameter FLUSH_CYCLES, default 4: modulator-reset hold length in clocks, 1..255.
REQ-004 CLOCK  input  1  clock; all logic on the rising edge.
REQ-005 RESET  input  1  reset, asynchronous, active-low.
REQ-006 ENABLE  input  1  level; 1 = run the modulator, 0 = stop at the next sample boundary.
REQ-007 S_VALID  input  1  host sample valid.
REQ-008 S_DATA  input  16  host sample word.
REQ-009 S_READY  output  1  sequencer can accept a sample (FIFO not full).
REQ-010 DATAWORD_OUT  output  16  sample driven to the modulator DATAWORD_IN.
REQ-011 MOD_RESET_N  output  1  active-low reset to the modulator RESET.
REQ-012 SAMPLE_STROBE  output  1  one-cycle pulse when DATAWORD_OUT takes a new sample.
REQ-013 UNDERRUN  output  1  high while in UNDERRUN state.
REQ-014 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-015 All outputs SHALL be registered, except S_READY, which SHALL be !full, decoded from registered FIFO state.
REQ-016 The FIFO SHALL push when S_VALID && S_READY in any state, including IDLE (prefill).
REQ-017 Pop SHALL see only registered FIFO contents: a same-cycle push SHALL NOT satisfy a pop on an empty FIFO.
REQ-018 States SHALL be IDLE, FLUSH, RUN and UNDERRUN.
REQ-019 IDLE: MOD_RESET_N=0, DATAWORD_OUT=0; go to FLUSH when ENABLE=1 and FIFO not empty.
REQ-020 FLUSH: hold MOD_RESET_N=0 for exactly FLUSH_CYCLES clocks, then pop a sample into DATAWORD_OUT, set MOD_RESET_N=1, pulse SAMPLE_STROBE, clear the OSR counter and enter RUN, all on the same edge.
REQ-021 ENABLE=0 during FLUSH SHALL return to IDLE on the next edge with no pop.
REQ-022 RUN: the OSR counter SHALL increment each clock and wrap at 2^OSR_LOG2-1 (terminal count).
REQ-023 At terminal count with ENABLE=1 and FIFO not empty, the block SHALL pop the next sample into DATAWORD_OUT and pulse SAMPLE_STROBE, so each sample is held exactly 2^OSR_LOG2 clocks.
REQ-024 At terminal count with ENABLE=1 and FIFO empty, the block SHALL enter UNDERRUN and hold the last DATAWORD_OUT; MOD_RESET_N SHALL stay 1.
REQ-025 At terminal count with ENABLE=0, the block SHALL enter IDLE; FIFO contents SHALL be retained.
REQ-026 UNDERRUN: on the first clock with FIFO not empty, the block SHALL pop, pulse SAMPLE_STROBE, clear the counter and return to RUN; if ENABLE=0, it SHALL go to IDLE instead.
REQ-027 ENABLE toggles mid-period in RUN SHALL NOT shorten the current sample period.
REQ-028 Push on a full FIFO SHALL be impossible (S_READY=0); a simultaneous pop and push when not full SHALL keep the occupancy unchanged.

Reset
REQ-029 Asynchronous RESET=0 SHALL force state IDLE, FIFO empty, counter 0, DATAWORD_OUT=0, MOD_RESET_N=0, SAMPLE_STROBE=0, UNDERRUN=0, BUSY=0, regardless of the current state.
REQ-030 After RESET deasserts, S_READY SHALL be 1 on the first clock.

Configuration
REQ-031 With SDM_SEQ_UNDERRUN_CNT_EN defined, the block SHALL add output UNDERRUN_COUNT[15:0], which increments on each RUN->UNDERRUN entry, saturates at 16'hFFFF, and is cleared only by RESET.
REQ-032 Without SDM_SEQ_UNDERRUN_CNT_EN, the UNDERRUN_COUNT port and its counter SHALL be absent.

Verification (OSR_LOG2=2, FIFO_DEPTH=4, FLUSH_CYCLES=4)
REQ-033 Push 16'h1000 with ENABLE=1 -> MOD_RESET_N low 4 clocks, then high with DATAWORD_OUT=16'h1000, SAMPLE_STROBE pulse, BUSY=1.
REQ-034 Push 16'h0100, 16'h0200, 16'h0300, then ENABLE=1 -> DATAWORD_OUT steps every 4 clocks, one strobe per step.
REQ-035 Push 5 samples with ENABLE=0 -> S_READY=0 after 4 pushes; the 5th is held off until the first pop.
REQ-036 Feed 1 sample only -> after 4 clocks UNDERRUN=1 with the word held; push 16'h0ABC -> next clock DATAWORD_OUT=16'h0ABC, UNDERRUN=0 (UNDERRUN_COUNT=1 when enabled).
REQ-037 Drop ENABLE at counter=1 in RUN -> IDLE entered after the terminal count; MOD_RESET_N=0, DATAWORD_OUT=0, the FIFO keeps its remaining entries.
REQ-038 Assert RESET in the middle of RUN -> all outputs take their REQ-029 values immediately, without waiting for a clock edge.
